// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: pattern table, blank/minus codes, converter states.
// Latency: none (constants and a pure function).
// Backpressure: none.
package seg_pkg;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_BLANK = 8'hff;
    localparam logic [7:0] SEG_MINUS = 8'hbf;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_e;

    // Hex digit to segment pattern, dp off.
    function automatic logic [7:0] seg_code(input logic [3:0] val);
        logic [7:0] pat;
        pat = SEG_BLANK;
        case (val)
            4'h0: pat = 8'hc0;
            4'h1: pat = 8'hf9;
            4'h2: pat = 8'ha4;
            4'h3: pat = 8'hb0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hf8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'ha: pat = 8'h88;
            4'hb: pat = 8'h83;
            4'hc: pat = 8'hc6;
            4'hd: pat = 8'ha1;
            4'he: pat = 8'h86;
            4'hf: pat = 8'h8e;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per clock.
// Latency: start_i cycle loads, then DATA_W shift cycles; done_o marks the last shift.
// Backpressure: none; a new start_i restarts the conversion immediately.
//   sys_clk/sys_rst_n : clock, async active-low reset
//   start_i, data_i   : load request and binary value
//   busy_o            : shifting in progress
//   done_o            : final shift this cycle, bcd_o valid from the next cycle
//   bcd_o             : ceil(DATA_W/3) packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq #(
    parameter int DATA_W = 20
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              start_i,
    input  logic [DATA_W-1:0]                 data_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [4*((DATA_W+2)/3)-1:0]       bcd_o
);

    localparam int BCD_DIG = (DATA_W + 2) / 3;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int CNT_W   = $clog2(DATA_W);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              last;

    // Add 3 to every digit >= 5 so the following left shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < BCD_DIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
    end

    assign last = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= data_i;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_dynamic.sv
// Multiplexed seven-segment driver: BCD/hex conversion, blanking, sign, dp, overflow, digit scan.
// Latency: buffer updates DATA_W+3 clocks after input capture (3 in hex); sel/seg registered.
// Backpressure: none; inputs are sampled once per conversion pass, changes in between are ignored.
//   data/point/sign/hex_mode : value and display options, captured while the converter is idle
//   seg_en                   : 0 forces the panel dark on the next clock
//   sel                      : one-hot active-high digit select, sel[0] rightmost
//   seg                      : active-low {dp,g,f,e,d,c,b,a}
module seg_dynamic
    import seg_pkg::*;
#(
    parameter int NUM_DIG  = 6,
    parameter int DATA_W   = 20,
    parameter int SCAN_MAX = 49_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [DATA_W-1:0]  data,
    input  logic [NUM_DIG-1:0] point,
    input  logic               sign,
    input  logic               hex_mode,
    input  logic               seg_en,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg
);

    localparam int BCD_DIG = (DATA_W + 2) / 3;
    localparam int BCD_W   = 4 * BCD_DIG;
    // Common digit vector wide enough for both the BCD result and the raw hex nibbles.
    localparam int VAL_W   = 4 * (NUM_DIG + BCD_DIG);
    localparam int CNT_W   = $clog2(SCAN_MAX + 1);
    localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int TOP_W   = $clog2(NUM_DIG + 1);

    conv_state_e               st_q;
    logic [DATA_W-1:0]         data_sh_q;
    logic [NUM_DIG-1:0]        point_sh_q;
    logic                      sign_sh_q;
    logic                      hex_sh_q;
    logic                      start_q;
    logic [BCD_W-1:0]          bcd;
    logic                      bcd_busy;
    logic                      bcd_done;
    logic [NUM_DIG-1:0][7:0]   buf_q, buf_d;
    logic [VAL_W-1:0]          val;
    logic                      ovf, ovf_all;
    logic [TOP_W-1:0]          top;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NUM_DIG-1:0]        sel_q;
    logic [7:0]                seg_q;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start_i   (start_q),
        .data_i    (data_sh_q),
        .busy_o    (bcd_busy),
        .done_o    (bcd_done),
        .bcd_o     (bcd)
    );

    // Display buffer image built from the shadow copy and the converter result.
    always_comb begin
        val = hex_sh_q ? VAL_W'(data_sh_q) : VAL_W'(bcd);
        ovf = |val[VAL_W-1:4*NUM_DIG];
        top = '0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if ((val[4*k +: 4] != 4'd0) || point_sh_q[k]) begin
                top = TOP_W'(k);
            end
        end
        // A minus sign with no free digit left has nowhere to go.
        ovf_all = ovf || (sign_sh_q && (top == TOP_W'(NUM_DIG - 1)));
        buf_d = '1;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (ovf_all) begin
                buf_d[k] = SEG_MINUS;
            end else if (TOP_W'(k) > top) begin
                buf_d[k] = (sign_sh_q && (TOP_W'(k) == top + TOP_W'(1))) ? SEG_MINUS : SEG_BLANK;
            end else begin
                buf_d[k] = seg_code(val[4*k +: 4]);
            end
            if (!ovf_all && point_sh_q[k]) begin
                buf_d[k][7] = 1'b0;
            end
        end
    end

    // Converter sequencing; the buffer is written whole in DONE so the panel never tears.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q       <= CONV_IDLE;
            data_sh_q  <= '0;
            point_sh_q <= '0;
            sign_sh_q  <= 1'b0;
            hex_sh_q   <= 1'b0;
            start_q    <= 1'b0;
            buf_q      <= {NUM_DIG{SEG_BLANK}};
        end else begin
            case (st_q)
                CONV_IDLE: begin
                    data_sh_q  <= data;
                    point_sh_q <= point;
                    sign_sh_q  <= sign;
                    hex_sh_q   <= hex_mode;
                    start_q    <= !hex_mode;
                    st_q       <= CONV_LOAD;
                end
                CONV_LOAD: begin
                    start_q <= 1'b0;
                    st_q    <= hex_sh_q ? CONV_DONE : CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    // !bcd_busy only guards against a converter that stopped early.
                    if (bcd_done || !bcd_busy) begin
                        st_q <= CONV_DONE;
                    end
                end
                CONV_DONE: begin
                    buf_q <= buf_d;
                    st_q  <= CONV_IDLE;
                end
                default: st_q <= CONV_IDLE;
            endcase
        end
    end

    // Scan: sel and seg both come from the same idx_q sample, so they never disagree.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            sel_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            if (cnt_q == CNT_W'(SCAN_MAX)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (seg_en) begin
                sel_q <= NUM_DIG'(1) << idx_q;
                seg_q <= buf_q[idx_q];
            end else begin
                sel_q <= '0;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic.sv
module tb_seg_dynamic;

    localparam int NUM_DIG  = 6;
    localparam int DATA_W   = 20;
    localparam int SCAN_MAX = 4;
    localparam int FRAME    = NUM_DIG * (SCAN_MAX + 1);

    typedef logic [NUM_DIG-1:0][7:0] frame_t;
    typedef struct {
        logic [DATA_W-1:0]  data;
        logic [NUM_DIG-1:0] point;
        logic               sign;
        logic               hex;
        frame_t             exp;
    } vec_t;

    localparam logic [7:0] SEG_TBL [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                                            8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

    logic               sys_clk   = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [DATA_W-1:0]  data;
    logic [NUM_DIG-1:0] point;
    logic               sign;
    logic               hex_mode;
    logic               seg_en;
    logic [NUM_DIG-1:0] sel;
    logic [7:0]         seg;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    seg_dynamic #(
        .NUM_DIG  (NUM_DIG),
        .DATA_W   (DATA_W),
        .SCAN_MAX (SCAN_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .hex_mode  (hex_mode),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    // Clock edges since the last reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    // What the panel must show, derived from the display rules with plain arithmetic.
    function automatic frame_t model(input int unsigned d, input logic [NUM_DIG-1:0] p,
                                     input logic s, input logic h);
        frame_t      f;
        int unsigned base, v, lim;
        int unsigned dig [NUM_DIG];
        int          top;
        logic        ovf;
        base = h ? 16 : 10;
        v    = d;
        lim  = 1;
        for (int i = 0; i < NUM_DIG; i++) begin
            dig[i] = v % base;
            v      = v / base;
            lim    = lim * base;
        end
        ovf = (d >= lim);
        top = 0;
        for (int i = 0; i < NUM_DIG; i++) if (dig[i] != 0 || p[i]) top = i;
        if (s && top == NUM_DIG - 1) ovf = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (ovf)          f[i] = 8'hbf;
            else if (i > top) f[i] = (s && i == top + 1) ? 8'hbf : 8'hff;
            else              f[i] = SEG_TBL[dig[i]];
            if (!ovf && p[i]) f[i][7] = 1'b0;
        end
        return f;
    endfunction

    // Collect one full scan period of seg values indexed by the active sel bit.
    task automatic read_frame(output frame_t fr);
        logic [NUM_DIG-1:0] seen;
        logic               bad;
        fr   = '1;
        seen = '0;
        bad  = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if ($onehot(sel)) begin
                for (int k = 0; k < NUM_DIG; k++) begin
                    if (sel[k]) begin
                        fr[k]   = seg;
                        seen[k] = 1'b1;
                    end
                end
            end else begin
                bad = 1'b1;
            end
        end
        check("frame_onehot_cover", {bad, seen}, {1'b0, 6'h3f});
    endtask

    // Scan sequence, blank buffer and exact first-result timing right after a reset release.
    // Capture happens at edge 1; the buffer is written at edge 23 and reaches seg at edge 24.
    task automatic post_reset_check(input logic [7:0] d4_exp);
        for (int m = 1; m <= 35; m++) begin
            tick();
            check("sel_scan", sel, 6'b1 << (((m - 1) / 5) % 6));
            if (m <= 23) check("blank_until_done", seg, 8'hff);
            if (m == 24) check("first_result_latency", seg, d4_exp);
        end
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_sel", sel, 6'h00);
        check("async_rst_seg", seg, 8'hff);
        tick();
        tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    vec_t   vecs [14];
    frame_t fr;
    frame_t f123456;
    frame_t f42;

    initial begin
        vecs[0]  = '{20'd123456, 6'b000000, 1'b0, 1'b0, {8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82}};
        vecs[1]  = '{20'd42,     6'b000000, 1'b1, 1'b0, {8'hff, 8'hff, 8'hff, 8'hbf, 8'h99, 8'ha4}};
        vecs[2]  = '{20'd0,      6'b000000, 1'b0, 1'b0, {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hc0}};
        vecs[3]  = '{20'd5,      6'b000100, 1'b0, 1'b0, {8'hff, 8'hff, 8'hff, 8'h40, 8'hc0, 8'h92}};
        vecs[4]  = '{20'd1000000,6'b000000, 1'b0, 1'b0, {6{8'hbf}}};
        vecs[5]  = '{20'hABCDE,  6'b000000, 1'b0, 1'b1, {8'hff, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86}};
        vecs[6]  = '{20'd999999, 6'b000000, 1'b1, 1'b0, {6{8'hbf}}};
        vecs[7]  = '{20'd999999, 6'b000000, 1'b0, 1'b0, {6{8'h90}}};
        vecs[8]  = '{20'd7,      6'b100000, 1'b1, 1'b0, {6{8'hbf}}};
        vecs[9]  = '{20'd3,      6'b001000, 1'b1, 1'b0, {8'hff, 8'hbf, 8'h40, 8'hc0, 8'hc0, 8'hb0}};
        vecs[10] = '{20'hFFFFF,  6'b000000, 1'b1, 1'b1, {8'hbf, 8'h8e, 8'h8e, 8'h8e, 8'h8e, 8'h8e}};
        vecs[11] = '{20'd0,      6'b000001, 1'b0, 1'b0, {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h40}};
        vecs[12] = '{20'h00010,  6'b000000, 1'b0, 1'b1, {8'hff, 8'hff, 8'hff, 8'hff, 8'hf9, 8'hc0}};
        vecs[13] = '{20'd100000, 6'b000000, 1'b0, 1'b0, {8'hf9, 8'hc0, 8'hc0, 8'hc0, 8'hc0, 8'hc0}};
        f123456  = vecs[0].exp;
        f42      = {8'hff, 8'hff, 8'hff, 8'hff, 8'h99, 8'ha4};

        // Reset held, then released on a falling edge.
        data = 20'd123456; point = '0; sign = 1'b0; hex_mode = 1'b0; seg_en = 1'b1;
        repeat (3) begin
            tick();
            check("rst_sel", sel, 6'h00);
            check("rst_seg", seg, 8'hff);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        post_reset_check(8'ha4);

        // Edge 35 is inside the second pass's SHIFT; the new value must wait for pass three.
        data = 20'd42;
        read_frame(fr);
        check("old_value_held", fr, f123456);
        tick_to(69);
        check("before_pass3_done", seg, 8'h92);
        tick();
        check("after_pass3_done", seg, 8'h99);

        // seg_en drop mid-digit, then re-enable at the free-running index.
        tick_to(72);
        seg_en = 1'b0;
        tick();
        check("disable_sel", sel, 6'h00);
        check("disable_seg", seg, 8'hff);
        repeat (5) tick();
        check("disabled_sel_hold", sel, 6'h00);
        check("disabled_seg_hold", seg, 8'hff);
        tick_to(91);
        seg_en = 1'b1;
        tick();
        begin
            int k;
            k = ((cyc - 1) / 5) % 6;
            check("reenable_sel", sel, 6'b1 << k);
            check("reenable_seg", seg, f42[k]);
        end

        // Table of display cases.
        for (int i = 0; i < 14; i++) begin
            data = vecs[i].data; point = vecs[i].point; sign = vecs[i].sign; hex_mode = vecs[i].hex;
            repeat (50) tick();
            read_frame(fr);
            check($sformatf("vec%0d", i), fr, vecs[i].exp);
        end

        // Randomized values against the reference model.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       data = 20'($urandom_range(0, 99));
                1:       data = 20'($urandom_range(0, 999999));
                2:       data = 20'($urandom);
                default: data = 20'($urandom_range(999990, 1000010));
            endcase
            point    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            sign     = 1'($urandom);
            hex_mode = ($urandom_range(0, 2) == 0);
            repeat (50) tick();
            read_frame(fr);
            check($sformatf("rand%0d", i), fr, model(int'(data), point, sign, hex_mode));
        end

        // Reset pulse in the middle of a SHIFT while the buffer holds a value.
        data = 20'd123456; point = '0; sign = 1'b0; hex_mode = 1'b0;
        pulse_reset();
        post_reset_check(8'ha4);
        data = 20'd654321;
        pulse_reset();
        post_reset_check(8'h92);
        read_frame(fr);
        check("after_reset_pulse", fr, model(654321, 6'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
